element_op_sched: RTL
=====================

# element_op_sched

Round-robin scheduler and sequencer that shares one row-wide element-wise arithmetic lane between two matrix requesters. It accepts an N×N pair of DW-bit matrices plus an opcode, processes the pair one row per cycle, buffers the result matrix, and returns it over a valid/ready handshake. It sits between the matrix producers and the shared element-wise datapath, so a single N-wide lane serves every element op in the design.

## Interface
- `N`, 8: matrix dimension; rows and columns.
- `DW`, 32: element width.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0_valid`  in  1  requester 0 has a command.
- `req0_ready`  out  1  requester 0 command accepted this cycle.
- `req0_op`  in  2  opcode: 00 add, 01 sub (a−b), 10 mul (low DW bits), 11 pass a.
- `req0_a`, `req0_b`  in  N*N*DW  operands, packed `[0:N-1][0:N-1][DW-1:0]`.
- `req1_valid`, `req1_ready`, `req1_op`, `req1_a`, `req1_b`: same as requester 0.
- `res_valid`  out  1  result matrix available.
- `res_ready`  in  1  consumer takes the result.
- `res_id`  out  1  requester that owns the result.
- `res_data`  out  N*N*DW  result matrix, same packing as the operands.

## Operation
- FSM states:
  - IDLE: if either valid is high, grant one requester, capture its op, a and b, and set `res_id`; go to RUN with row=0.
  - RUN: compute row `row` through the lane into the result buffer, then row++. After row N−1, go to DONE.
  - DONE: hold `res_valid`=1; on `res_ready`, go to IDLE.
- Arbitration:
  - Round-robin; the requester not granted last has priority.
  - After reset, requester 0 has priority.
  - A lone valid is always granted.
  - `reqX_ready` is combinational: high only in IDLE, for the granted requester, and only while its valid is high.
- Arithmetic:
  - Elementwise, modulo 2^DW, no saturation, no flags.
  - sub wraps (5−7 = 0xFFFFFFFE).
  - mul keeps bits [DW-1:0] of the full product.
  - Opcode is latched at accept; `reqX_op` changes after accept are ignored.
- Operand and result buffers:
  - Operands are registered at accept.
  - Requesters may change `a`, `b`, `op` in the cycle after their ready.
  - `res_data` holds stable from `res_valid` rise until the handshake.
  - Rows not yet written keep their previous contents; nothing reads them before DONE.
- Boundary conditions:
  - Valid arriving while RUN or DONE: stalls with ready=0; no command is lost or dropped.
  - Valid deasserted before grant: no effect.
  - Both valids high in IDLE: exactly one ready high.
  - `res_ready` high outside DONE: ignored.
- Reset (asynchronous, any state):
  - FSM to IDLE, row=0, priority to requester 0.
  - `res_valid`=0, `res_id`=0, `res_data`=0, both readies 0 while `rst_n`=0.
  - An in-flight command is discarded.

## Timing
- Accept at edge T; row r is written at edge T+1+r.
- `res_valid` rises after edge T+N (cycle T+N+1 for N=8: 9 cycles after accept).
- Earliest next accept is the cycle after the result handshake. Minimum issue interval is N+2 cycles.
- No combinational path from `res_ready` to `res_data`. The only combinational output paths are the `reqX_ready` signals, which depend on state, valids and priority.

## Structure
- Package `element_op_pkg`: opcode localparams (`OP_ADD`, `OP_SUB`, `OP_MUL`, `OP_PASS`) and the state enum (`S_IDLE`, `S_RUN`, `S_DONE`).
- Sub-module `element_lane`: combinational, N parallel DW-bit units selected by op; inputs one row of a and one row of b, output one row. Instantiated once and shared across rows; this is the shared resource.
- Scheduler top: arbiter, FSM, row counter ($clog2(N) bits), operand/result buffers.

## Test plan
- Add, N=8:
  - Stimulus: requester 0, op 00; a[0][1]=1, a[1][0]=2, a[1][1]=3; b identical; all other elements 0.
  - Required: `res_valid` 9 cycles after ready; `res_id`=0; result[0][1]=2, [1][0]=4, [1][1]=6, all others 0.
- Sub/mul wrap:
  - Sub with 5−7 gives 0xFFFFFFFE.
  - Mul 0x00010000×0x00010000 gives 0.
  - Mul 3×0xFFFFFFFF gives 0xFFFFFFFD.
- Arbitration:
  - Both valids high from reset: requester 0 is granted first, requester 1 after the first handshake.
  - Both held high afterwards: grants alternate 0,1,0,1.
- Backpressure:
  - Hold `res_ready`=0 for 5 cycles in DONE.
  - `res_data` and `res_id` stay stable; both readies stay 0 with both valids high.
  - Handshake on cycle 6; the next grant follows one cycle later.
- Reset mid-RUN:
  - Drop `rst_n` at row 3.
  - Outputs go to 0 immediately; after release, a new command completes correctly in 9 cycles.

Source files
------------

// File: rtl/element_op_pkg.sv
// Shared opcode encodings and scheduler state type for the element-wise op scheduler.
package element_op_pkg;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_MUL  = 2'b10;
  localparam logic [1:0] OP_PASS = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/element_op_sched_lane.sv
// Shared row-wide element-wise arithmetic lane: N parallel DW-bit units, modulo 2^DW.
module element_lane
  import element_op_pkg::*;
#(
  parameter int N  = 8,
  parameter int DW = 32
) (
  input  logic [1:0]      op,
  input  logic [N*DW-1:0] a_row,
  input  logic [N*DW-1:0] b_row,
  output logic [N*DW-1:0] res_row
);

  logic [0:N-1][DW-1:0] a_v;
  logic [0:N-1][DW-1:0] b_v;
  logic [0:N-1][DW-1:0] r_v;

  assign a_v     = a_row;
  assign b_v     = b_row;
  assign res_row = r_v;

  // Per-element op select; products are evaluated at DW width so only the low bits remain.
  always_comb begin
    r_v = '0;
    for (int unsigned i = 0; i < N; i++) begin
      case (op)
        OP_ADD:  r_v[i] = a_v[i] + b_v[i];
        OP_SUB:  r_v[i] = a_v[i] - b_v[i];
        OP_MUL:  r_v[i] = a_v[i] * b_v[i];
        default: r_v[i] = a_v[i];
      endcase
    end
  end

endmodule

// File: rtl/element_op_sched.sv
// Round-robin scheduler sharing one element lane between two matrix requesters,
// processing one row per cycle and holding the result matrix until handshake.
module element_op_sched
  import element_op_pkg::*;
#(
  parameter int N  = 8,
  parameter int DW = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [1:0]        req0_op,
  input  logic [N*N*DW-1:0] req0_a,
  input  logic [N*N*DW-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [1:0]        req1_op,
  input  logic [N*N*DW-1:0] req1_a,
  input  logic [N*N*DW-1:0] req1_b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_id,
  output logic [N*N*DW-1:0] res_data
);

  localparam int RW = (N > 1) ? $clog2(N) : 1;

  typedef logic [0:N-1][0:N-1][DW-1:0] mat_t;

  state_e        state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic          prio_q, prio_d;   // 1: requester 1 wins a tie
  logic [1:0]    op_q, op_d;
  mat_t          a_q, a_d;
  mat_t          b_q, b_d;
  mat_t          res_q, res_d;
  logic          id_q, id_d;

  logic          gnt_id;
  logic          accept;
  logic [N*DW-1:0] lane_out;

  element_lane #(
    .N  (N),
    .DW (DW)
  ) u_lane (
    .op      (op_q),
    .a_row   (a_q[row_q]),
    .b_row   (b_q[row_q]),
    .res_row (lane_out)
  );

  // Arbiter: a lone valid always wins; a tie goes to the requester not granted last.
  // Readies are gated by rst_n so they stay low throughout reset.
  always_comb begin
    gnt_id     = (req0_valid && req1_valid) ? prio_q : req1_valid;
    accept     = rst_n && (state_q == S_IDLE) && (req0_valid || req1_valid);
    req0_ready = accept && !gnt_id;
    req1_ready = accept && gnt_id;
  end

  // Next-state logic: capture on accept, one row through the lane per RUN cycle, hold in DONE.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    prio_d  = prio_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    id_d    = id_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d    = gnt_id ? req1_op : req0_op;
          a_d     = gnt_id ? req1_a  : req0_a;
          b_d     = gnt_id ? req1_b  : req0_b;
          id_d    = gnt_id;
          prio_d  = ~gnt_id;
          row_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        res_d[row_q] = lane_out;
        if (row_q == RW'(N - 1)) begin
          row_d   = '0;
          state_d = S_DONE;
        end else begin
          row_d = row_q + 1'b1;
        end
      end
      S_DONE: begin
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and buffer registers; reset discards any in-flight command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      prio_q  <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      id_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      prio_q  <= prio_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      id_q    <= id_d;
    end
  end

  assign res_valid = (state_q == S_DONE);
  assign res_id    = id_q;
  assign res_data  = res_q;

endmodule
